// File: rtl/jk_bank_ctrl_pkg.sv
// Shared types for the JK bank controller: command opcodes, FSM states and
// the expected read-back rule for a single JK flip-flop.
package jk_bank_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'b00,
        OP_RESET  = 2'b01,
        OP_SET    = 2'b10,
        OP_TOGGLE = 2'b11
    } jk_op_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CHECK
    } ctrl_state_e;

    // What Q must read after one clock of {J,K}=op, given Q before that clock.
    function automatic logic expected_q(jk_op_e op, logic q_prev);
        case (op)
            OP_HOLD:   return q_prev;
            OP_RESET:  return 1'b0;
            OP_SET:    return 1'b1;
            OP_TOGGLE: return ~q_prev;
            default:   return q_prev;
        endcase
    endfunction

endpackage

// File: rtl/jk_bank_ctrl_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the internal
// pointer, and moves the pointer past the winner when advance is asserted.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int W = $clog2(N);

    logic [W-1:0] ptr;
    logic         found;
    int           c;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = W'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == W'(N - 1)) ? '0 : grant_idx + W'(1);
        end
    end

endmodule

// File: rtl/jk_bank_ctrl.sv
// Command sequencer sharing one JK flip-flop bank between NUM_REQ requesters.
// Define JK_BANK_CTRL_PRIO_EN to give requester 0 strict priority over the rest.
module jk_bank_ctrl
    import jk_bank_ctrl_pkg::*;
#(
    parameter  int NUM_REQ  = 4,
    parameter  int NUM_BITS = 8,
    localparam int IDX_W    = $clog2(NUM_BITS),
    localparam int REQ_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [IDX_W*NUM_REQ-1:0]  req_idx,
    output logic [NUM_BITS-1:0]       jk_j,
    output logic [NUM_BITS-1:0]       jk_k,
    input  logic [NUM_BITS-1:0]       jk_q,
    output logic                      done_valid,
    output logic [REQ_W-1:0]          done_id,
    output logic                      done_q,
    output logic                      done_err,
    output logic                      err_sticky
);

    localparam int EXT_W = 1 << IDX_W;

    ctrl_state_e state, state_nxt;

    logic [NUM_REQ-1:0]  arb_req, arb_grant, grant;
    logic [REQ_W-1:0]    arb_idx, win_id;
    logic                accept, advance;
    logic [1:0]          win_op;
    logic [IDX_W-1:0]    win_idx;
    logic                win_bad;
    logic [NUM_BITS-1:0] win_sel;

    jk_op_e              op_q;
    logic [IDX_W-1:0]    idx_q;
    logic [REQ_W-1:0]    id_q;
    logic                bad_q;
    logic                q_prev;
    logic [EXT_W-1:0]    q_ext;
    logic                q_sel;

    assign accept = (state == IDLE) && !rst && (|req_valid);

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (arb_req),
        .advance   (advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

`ifdef JK_BANK_CTRL_PRIO_EN
    // Requester 0 bypasses the arbiter entirely so its wins never move the pointer.
    always_comb begin
        arb_req    = req_valid;
        arb_req[0] = 1'b0;
        if (req_valid[0]) begin
            grant  = NUM_REQ'(1);
            win_id = '0;
        end else begin
            grant  = arb_grant;
            win_id = arb_idx;
        end
        advance = accept && !req_valid[0];
    end
`else
    always_comb begin
        arb_req = req_valid;
        grant   = arb_grant;
        win_id  = arb_idx;
        advance = accept;
    end
`endif

    always_comb begin
        win_op  = '0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_op  = req_op[2*i +: 2];
                win_idx = req_idx[IDX_W*i +: IDX_W];
            end
        end
    end

    // Indices past the end of a non-power-of-two bank drive nothing.
    assign win_bad = {1'b0, win_idx} >= (IDX_W + 1)'(NUM_BITS);
    assign win_sel = win_bad ? '0 : (NUM_BITS'(1) << win_idx);
    assign q_ext   = EXT_W'(jk_q);
    assign q_sel   = q_ext[idx_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = CHECK;
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        done_valid = 1'b0;
        done_id    = '0;
        done_q     = 1'b0;
        done_err   = 1'b0;
        case (state)
            IDLE:    if (!rst) req_ready = grant;
            CHECK: begin
                done_valid = 1'b1;
                done_id    = id_q;
                done_q     = bad_q ? 1'b0 : q_sel;
                done_err   = bad_q || (q_sel != expected_q(op_q, q_prev));
            end
            default: ;
        endcase
    end

    // J/K are loaded on the accept edge so they are high for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            jk_j       <= '0;
            jk_k       <= '0;
            op_q       <= OP_HOLD;
            idx_q      <= '0;
            id_q       <= '0;
            bad_q      <= 1'b0;
            q_prev     <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            jk_j <= '0;
            jk_k <= '0;
            if (accept) begin
                op_q  <= jk_op_e'(win_op);
                idx_q <= win_idx;
                id_q  <= win_id;
                bad_q <= win_bad;
                jk_j  <= win_sel & {NUM_BITS{win_op[1]}};
                jk_k  <= win_sel & {NUM_BITS{win_op[0]}};
            end
            if (state == ISSUE) q_prev <= q_sel;
            if (done_err) err_sticky <= 1'b1;
        end
    end

endmodule
